// File: rtl/interboard_tx_scheduler.sv
// interboard_tx_scheduler: two-port (S priority, G anti-starvation) FIFO scheduler for the interboard sender with timeout retry.
module interboard_tx_scheduler #(
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 1023,
    parameter int MAX_RETRY    = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       sys_en,
    input  logic [2:0] sys_msg_type,
    input  logic [4:0] sys_number,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    output logic       tx_valid,
    output logic [2:0] tx_msg_type,
    output logic [4:0] tx_number,
    input  logic       tx_ready,
    input  logic       tx_done,
    output logic       inter_ready,
    output logic       sys_ready,
    output logic       tx_err,
    output logic [1:0] overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
    state_t state, state_n;
    logic [7:0] s_mem [DEPTH];
    logic [7:0] g_mem [DEPTH];
    logic [AW-1:0] s_wp, s_rp, g_wp, g_rp;
    logic [CW-1:0] s_cnt, g_cnt;
    logic s_full, s_empty, g_full, g_empty, s_push, g_push, s_pop, g_pop;
    logic sel, sel_n;
    logic [TW-1:0] wcnt, wcnt_n;
    logic [RW-1:0] retry, retry_n;
    logic [SW-1:0] starve, starve_n;
    logic [7:0] tx_ent, tx_ent_n;
    logic tx_valid_n, pop, retire, err_n;
    assign s_full  = s_cnt == CW'(DEPTH);
    assign g_full  = g_cnt == CW'(DEPTH);
    assign s_empty = s_cnt == '0;
    assign g_empty = g_cnt == '0;
    assign s_push  = sys_en && !s_full;
    assign g_push  = ctrl_en && !g_full;
    assign s_pop   = pop && !sel;
    assign g_pop   = pop && sel;
    assign {tx_msg_type, tx_number} = tx_ent;
    always_ff @(posedge clk) begin
        if (s_push) s_mem[s_wp] <= {sys_msg_type, sys_number};
        if (g_push) g_mem[g_wp] <= {ctrl_msg_type, ctrl_number};
    end
    // sel=1 means port G owns the transfer; the latched entry is never re-read from the FIFO
    always_comb begin
        state_n    = state;
        sel_n      = sel;
        wcnt_n     = wcnt;
        retry_n    = retry;
        starve_n   = starve;
        tx_ent_n   = tx_ent;
        tx_valid_n = tx_valid;
        pop        = 1'b0;
        retire     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: if (!s_empty || !g_empty) begin
                sel_n      = s_empty || (starve == SW'(STARVE_LIMIT) && !g_empty);
                tx_ent_n   = sel_n ? g_mem[g_rp] : s_mem[s_rp];
                starve_n   = (!sel_n && !g_empty) ? starve + 1'b1 : '0;
                tx_valid_n = 1'b1;
                state_n    = ISSUE;
            end
            ISSUE: if (tx_ready) begin
                tx_valid_n = 1'b0;
                wcnt_n     = '0;
                state_n    = WAIT_DONE;
            end
            WAIT_DONE: begin
                wcnt_n = wcnt + 1'b1;
                if (tx_done) begin
                    pop     = 1'b1;
                    retire  = 1'b1;
                    retry_n = '0;
                    state_n = IDLE;
                end else if (wcnt_n == TW'(TIMEOUT)) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = GAP;
                    end else begin
                        pop     = 1'b1;
                        retire  = 1'b1;
                        err_n   = 1'b1;
                        retry_n = '0;
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                tx_valid_n = 1'b1;
                state_n    = ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state       <= IDLE;
            s_wp        <= '0;
            s_rp        <= '0;
            g_wp        <= '0;
            g_rp        <= '0;
            s_cnt       <= '0;
            g_cnt       <= '0;
            sel         <= 1'b0;
            wcnt        <= '0;
            retry       <= '0;
            starve      <= '0;
            tx_ent      <= '0;
            tx_valid    <= 1'b0;
            inter_ready <= 1'b0;
            sys_ready   <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_n;
            if (s_push) s_wp <= s_wp + 1'b1;
            if (g_push) g_wp <= g_wp + 1'b1;
            if (s_pop) s_rp <= s_rp + 1'b1;
            if (g_pop) g_rp <= g_rp + 1'b1;
            s_cnt       <= s_cnt + CW'(s_push) - CW'(s_pop);
            g_cnt       <= g_cnt + CW'(g_push) - CW'(g_pop);
            sel         <= sel_n;
            wcnt        <= wcnt_n;
            retry       <= retry_n;
            starve      <= starve_n;
            tx_ent      <= tx_ent_n;
            tx_valid    <= tx_valid_n;
            inter_ready <= retire && sel;
            sys_ready   <= retire && !sel;
            tx_err      <= err_n;
        end
    end
    // overflow survives a peer restart; only a full reset clears it
    always_ff @(posedge clk) begin
        if (rst) overflow <= 2'b00;
        else if (!interboard_rst) overflow <= overflow | {ctrl_en && g_full, sys_en && s_full};
    end
endmodule

// File: doc/interboard_tx_scheduler.md
Name: interboard_tx_scheduler

Overview:
- Shares the single interboard message sender between two requesters: the system/reset requester (port S, high priority) and the game master FSM (port G).
- Each port has its own FIFO.
- Grants one message at a time to the sender with a valid/ready handshake, then waits for frame completion, retrying on timeout.
- Returns per-port completion pulses. Port G's pulse is the `inter_ready` that the game FSM uses to advance its SEND_* states.

Parameters:
- DEPTH, 4, entries per requester FIFO (power of 2, ≥2)
- TIMEOUT, 1023, cycles to wait for tx_done after the sender accepts
- MAX_RETRY, 2, re-issues after the first attempt before the message is dropped
- STARVE_LIMIT, 3, consecutive S grants with G pending before G is forced

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous flush (peer-initiated restart)
- sys_en  in  1  push to S FIFO
- sys_msg_type  in  3  S message type
- sys_number  in  5  S number
- ctrl_en  in  1  push to G FIFO
- ctrl_msg_type  in  3  G message type
- ctrl_number  in  5  G number
- tx_valid  out  1  message offered to sender
- tx_msg_type  out  3  offered type
- tx_number  out  5  offered number
- tx_ready  in  1  sender accepts (handshake when tx_valid && tx_ready)
- tx_done  in  1  sender finished the frame
- inter_ready  out  1  one-cycle pulse: G message retired
- sys_ready  out  1  one-cycle pulse: S message retired
- tx_err  out  1  one-cycle pulse: message dropped after retries
- overflow  out  2  sticky; bit0 = S push while full, bit1 = G push while full

Behaviour:
- Entry format: {msg_type[2:0], number[4:0]}, 8 bits.
- Push on en when the FIFO is not full. A push while full is discarded and sets the overflow bit.
- Push and pop on the same FIFO in the same cycle both occur; occupancy is unchanged.
- All outputs are registered.
- Reset (rst): FIFOs empty, state IDLE, all counters 0, tx_valid=0, tx fields=0, pulses=0, overflow=0.
- interboard_rst has the same effect as rst, except overflow is kept.
- Either reset mid-transfer abandons the in-flight message: no pulses, tx_valid=0 after the edge.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: if either FIFO is non-empty, select a port, latch its head, and go to ISSUE.
  - Select S if non-empty, unless starve_cnt==STARVE_LIMIT and G is non-empty; in that case select G.
  - starve_cnt increments on an S grant while G is non-empty.
  - starve_cnt clears on a G grant, or on an S grant with G empty.
  - Latency: push at edge N into an idle, empty scheduler gives tx_valid=1 after edge N+1.
- ISSUE: tx_valid=1. tx fields are held stable until the handshake. tx_valid && tx_ready → go to WAIT_DONE, tx_valid=0, wait counter = 0.
- WAIT_DONE: counter increments each cycle.
  - tx_done → pop the granted FIFO, pulse that port's ready output, reset retry count, go to IDLE.
  - Counter reaches TIMEOUT without tx_done:
    - If retry < MAX_RETRY: retry++, go to GAP.
    - Otherwise: pop, pulse tx_err and the port's ready output in the same cycle (so the game FSM never hangs), go to IDLE.
  - tx_done in the same cycle the counter reaches TIMEOUT counts as success.
- GAP: one cycle with tx_valid=0, then ISSUE with the same latched entry. The head is not re-read; new pushes do not alter it.
- tx_done outside WAIT_DONE is ignored.
- No arbitration during a transfer; at most one message is in flight.
- Minimum spacing between retirements is 2 cycles (IDLE → ISSUE).

Test Plan:
- Single G push {3'd2, 5'd17} while idle → tx_valid after 1 edge with type 2, number 17. tx_ready at the next cycle, tx_done 5 cycles later → inter_ready pulses for exactly 1 cycle; FIFO empty.
- Same cycle: S push {1,0} and G push {2,5} → S offered first. After its tx_done, sys_ready pulses, then G is offered next and inter_ready pulses after its tx_done.
- Keep S continuously non-empty with G pending, STARVE_LIMIT=3 → grant order S,S,S,G,S…
- Never assert tx_done, TIMEOUT=8, MAX_RETRY=2 → 3 handshakes total, each separated by a GAP cycle. After the third timeout, tx_err and inter_ready pulse together; the entry is popped.
- 5 G pushes with tx_ready=0, DEPTH=4 → overflow=2'b10 and 4 entries retained. Then assert interboard_rst → FIFOs empty, tx_valid=0, overflow still 2'b10. Then rst → overflow=0.
- tx_done held high during IDLE/ISSUE → no pulses. Assert rst during WAIT_DONE → no inter_ready, state IDLE.
